// File: rtl/adder_arbiter.sv
// Two requesters time-share one carry-select adder through 1-entry request buffers
// and a round-robin arbiter; each port gets a registered result with a one-cycle valid pulse.

module adder_arbiter_rca #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);
  logic [W:0] w_c;
  assign w_c[0] = i_cin;
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end
  assign o_cout = w_c[W];
endmodule

module csa_32b_by_rca (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);
  localparam int BLK = 8;
  localparam int NB  = 32 / BLK;
  logic [NB:0] w_c;
  assign w_c[0] = i_cin;
  for (genvar i = 0; i < NB; i++) begin : g_blk
    if (i == 0) begin : g_lsb
      adder_arbiter_rca #(.W(BLK)) u_rca (
        .i_a(i_a[BLK-1:0]), .i_b(i_b[BLK-1:0]), .i_cin(w_c[0]),
        .o_sum(o_sum[BLK-1:0]), .o_cout(w_c[1]));
    end else begin : g_sel
      // Upper blocks precompute both carry-in cases; the incoming carry only selects.
      logic [BLK-1:0] w_s0, w_s1;
      logic           w_c0, w_c1;
      adder_arbiter_rca #(.W(BLK)) u_rca0 (
        .i_a(i_a[i*BLK +: BLK]), .i_b(i_b[i*BLK +: BLK]), .i_cin(1'b0),
        .o_sum(w_s0), .o_cout(w_c0));
      adder_arbiter_rca #(.W(BLK)) u_rca1 (
        .i_a(i_a[i*BLK +: BLK]), .i_b(i_b[i*BLK +: BLK]), .i_cin(1'b1),
        .o_sum(w_s1), .o_cout(w_c1));
      assign o_sum[i*BLK +: BLK] = w_c[i] ? w_s1 : w_s0;
      assign w_c[i+1]            = w_c[i] ? w_c1 : w_c0;
    end
  end
  assign o_cout = w_c[NB];
endmodule

module adder_arbiter_port #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  input  logic             i_gnt,
  input  logic [WIDTH-1:0] i_res,
  input  logic             i_cout,
  input  logic             i_ovf,
  output logic             o_ready,
  output logic             o_full,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  output logic             o_sub,
  output logic             o_rsp_valid,
  output logic [WIDTH-1:0] o_rsp_result,
  output logic             o_rsp_cout,
  output logic             o_rsp_ovf
);
  logic             r_full, r_sub, r_rsp_valid, r_rsp_cout, r_rsp_ovf;
  logic [WIDTH-1:0] r_a, r_b, r_rsp_result;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_full       <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_sub        <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_cout   <= 1'b0;
      r_rsp_ovf    <= 1'b0;
    end else begin
      r_rsp_valid <= i_gnt;
      // A full buffer never accepts, so grant and accept are mutually exclusive here.
      if (i_gnt) begin
        r_full       <= 1'b0;
        r_rsp_result <= i_res;
        r_rsp_cout   <= i_cout;
        r_rsp_ovf    <= i_ovf;
      end else if (i_valid && !r_full) begin
        r_full <= 1'b1;
        r_a    <= i_a;
        r_b    <= i_b;
        r_sub  <= i_sub;
      end
    end
  end

  assign o_ready      = ~r_full & reset_n;
  assign o_full       = r_full;
  assign o_a          = r_a;
  assign o_b          = r_b;
  assign o_sub        = r_sub;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_cout   = r_rsp_cout;
  assign o_rsp_ovf    = r_rsp_ovf;
endmodule

module adder_arbiter #(
  parameter int WIDTH = 32  // must stay 32 to match the shared adder
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_cout,
  output logic             rsp0_ovf,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_cout,
  output logic             rsp1_ovf,
  output logic             busy
);
  localparam int NUM_PORTS = 2;

  logic [NUM_PORTS-1:0]            w_valid, w_sub, w_ready, w_full, w_bsub, w_gnt;
  logic [NUM_PORTS-1:0]            w_rv, w_rco, w_rov;
  logic [NUM_PORTS-1:0][WIDTH-1:0] w_a, w_b, w_ba, w_bb, w_rres;
  logic [WIDTH-1:0]                w_opa, w_bsel, w_opb, w_sum;
  logic                            w_selsub, w_cout, w_ovf;
  logic                            r_ptr;

  assign w_valid = {req1_valid, req0_valid};
  assign w_sub   = {req1_sub, req0_sub};
  assign w_a     = {req1_a, req0_a};
  assign w_b     = {req1_b, req0_b};

  // Contention goes to r_ptr; a lone full buffer always wins.
  assign w_gnt[0] = w_full[0] & (~w_full[1] | ~r_ptr);
  assign w_gnt[1] = w_full[1] & (~w_full[0] |  r_ptr);

  assign w_opa    = w_gnt[1] ? w_ba[1]   : w_ba[0];
  assign w_bsel   = w_gnt[1] ? w_bb[1]   : w_bb[0];
  assign w_selsub = w_gnt[1] ? w_bsub[1] : w_bsub[0];
  assign w_opb    = w_selsub ? ~w_bsel : w_bsel;

  csa_32b_by_rca u_add (
    .i_a(w_opa), .i_b(w_opb), .i_cin(w_selsub), .o_sum(w_sum), .o_cout(w_cout));

  assign w_ovf = (w_opa[WIDTH-1] == w_opb[WIDTH-1]) & (w_sum[WIDTH-1] != w_opa[WIDTH-1]);

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    adder_arbiter_port #(.WIDTH(WIDTH)) u_port (
      .clock(clock), .reset_n(reset_n),
      .i_valid(w_valid[k]), .i_a(w_a[k]), .i_b(w_b[k]), .i_sub(w_sub[k]),
      .i_gnt(w_gnt[k]), .i_res(w_sum), .i_cout(w_cout), .i_ovf(w_ovf),
      .o_ready(w_ready[k]), .o_full(w_full[k]),
      .o_a(w_ba[k]), .o_b(w_bb[k]), .o_sub(w_bsub[k]),
      .o_rsp_valid(w_rv[k]), .o_rsp_result(w_rres[k]),
      .o_rsp_cout(w_rco[k]), .o_rsp_ovf(w_rov[k]));
  end

  always_ff @(posedge clock) begin
    if (!reset_n)      r_ptr <= 1'b0;
    else if (w_gnt[0]) r_ptr <= 1'b1;
    else if (w_gnt[1]) r_ptr <= 1'b0;
  end

  assign req0_ready  = w_ready[0];
  assign req1_ready  = w_ready[1];
  assign rsp0_valid  = w_rv[0];
  assign rsp1_valid  = w_rv[1];
  assign rsp0_result = w_rres[0];
  assign rsp1_result = w_rres[1];
  assign rsp0_cout   = w_rco[0];
  assign rsp1_cout   = w_rco[1];
  assign rsp0_ovf    = w_rov[0];
  assign rsp1_ovf    = w_rov[1];
  assign busy        = (|w_full) | (|w_rv);
endmodule
